// File: rtl/buton_debounce_pkg.sv
// Shared types and constants for the push-button conditioning path.
package buton_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // System clock frequency, shared with the traffic-light clock divider.
  localparam int CLK_FREQ_HZ = 12000000;

endpackage

// File: rtl/buton_debounce_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
// Resets asynchronously (active-low) to RST_VAL so idle pads read inactive.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/buton_debounce.sv
// Pedestrian button conditioner: sync, debounce FSM, held active-low request.
// Long-press detection is built only when LONG_PRESS_EN is defined.
module buton_debounce
  import buton_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int HOLD_CYCLES     = 24000000
) (
  input  logic clk,
  input  logic rst,
  input  logic buton_raw,
  input  logic ack,
  output logic buton,
  output logic press_pulse,
  output logic long_press,
  output logic pressed
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > DEBOUNCE_CYCLES) ? HOLD_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] C_DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic       w_s;
  logic       w_press_evt;
  deb_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic       r_press_pulse;
  logic       r_pressed;
  logic       r_req;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (buton_raw),
    .q   (w_s)
  );

  assign w_press_evt = (r_state == PRESS_WAIT) && !w_s && (r_cnt == C_DEB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_press_pulse <= 1'b0;
      r_pressed     <= 1'b0;
    end else begin
      r_press_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (w_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_DEB_LAST) begin
            r_state       <= PRESSED;
            r_cnt         <= '0;
            r_press_pulse <= 1'b1;
            r_pressed     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (w_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!w_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == C_DEB_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Set covers both the accept edge and the pulse cycle, so an ack coinciding
  // with press_pulse can never swallow the new press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req <= 1'b0;
    end else begin
      r_req <= w_press_evt | r_press_pulse | (r_req & ~ack);
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic          w_release_evt;
  logic [CW-1:0] r_hold_cnt;
  logic          r_long_done;
  logic          r_long_press;

  assign w_release_evt = (r_state == RELEASE_WAIT) && w_s && (r_cnt == C_DEB_LAST);

  // Counts only while settled in PRESSED; bounce time in RELEASE_WAIT is not credited.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_cnt   <= '0;
      r_long_done  <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if (w_release_evt) begin
        r_hold_cnt  <= '0;
        r_long_done <= 1'b0;
      end else if (r_state == PRESSED) begin
        if (r_hold_cnt == C_HOLD_LAST) begin
          if (!r_long_done) begin
            r_long_press <= 1'b1;
            r_long_done  <= 1'b1;
          end
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  assign long_press = r_long_press;
`else
  assign long_press = 1'b0;
`endif

  assign buton       = ~r_req;
  assign press_pulse = r_press_pulse;
  assign pressed     = r_pressed;

endmodule

// File: tb/tb_buton_debounce.sv
// Scoreboard bench for buton_debounce: run-length reference model feeds an
// expected-output queue that a negedge monitor drains every cycle.
module tb_buton_debounce;

  localparam int D = 8;
  localparam int H = 32;
`ifdef LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic buton_raw;
  logic ack;
  logic buton;
  logic press_pulse;
  logic long_press;
  logic pressed;

  buton_debounce #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buton_raw   (buton_raw),
    .ack         (ack),
    .buton       (buton),
    .press_pulse (press_pulse),
    .long_press  (long_press),
    .pressed     (pressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic buton;
    logic pulse;
    logic lng;
    logic pressed;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;

  // Reference model: pad delayed two samples, level flips after D+1
  // consecutive opposite samples, hold time counts settled pressed samples.
  logic m_sq0, m_sq1, m_level, m_pulse, m_long, m_req, m_done, m_evt;
  int   m_run, m_hold;
  bit   ack_on_pulse = 1'b0;

  task automatic model_reset();
    m_sq0 = 1'b1; m_sq1 = 1'b1; m_level = 1'b0; m_run = 0; m_hold = 0;
    m_done = 1'b0; m_pulse = 1'b0; m_long = 1'b0; m_req = 1'b0; m_evt = 1'b0;
  endtask

  task automatic model_edge();
    logic s, opp, fire, settled;
    if (!rst) begin
      model_reset();
      return;
    end
    s = m_sq1; m_sq1 = m_sq0; m_sq0 = buton_raw;
    m_evt = 1'b0; fire = 1'b0;
    settled = m_level && (m_run == 0);
    if (LP && settled) begin
      if (m_hold == H - 1 && !m_done) begin
        fire = 1'b1; m_done = 1'b1;
      end else if (m_hold < H - 1) begin
        m_hold++;
      end
    end
    opp = m_level ? s : !s;
    if (opp) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = !m_level;
        m_run = 0;
        if (m_level) m_evt = 1'b1;
        else begin m_hold = 0; m_done = 1'b0; end
      end
    end else begin
      m_run = 0;
    end
    m_req = m_evt | m_pulse | (m_req & ~ack);
    m_pulse = m_evt;
    m_long = fire;
  endtask

  task automatic cyc(input logic raw, input logic a, input logic r);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    buton_raw = raw;
    ack = a | (ack_on_pulse & m_evt);
    rst = r;
    if (!r) model_reset();
    e.buton = ~m_req; e.pulse = m_pulse; e.lng = m_long; e.pressed = m_level;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_no, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc_no++;
        check("buton", buton, e.buton);
        check("press_pulse", press_pulse, e.pulse);
        check("long_press", long_press, e.lng);
        check("pressed", pressed, e.pressed);
        if (e.pulse) $display("cycle %0d: press accepted, buton=%b", cyc_no, buton);
        if (e.lng)   $display("cycle %0d: long press flagged", cyc_no);
      end
    end
  end

  initial begin
    logic raw_lvl;
    int   seg;
    rst = 1'b0; buton_raw = 1'b1; ack = 1'b0;
    model_reset();

    // Reset held with a toggling pad, then quiet release.
    for (int i = 0; i < 6; i++) cyc(logic'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (50) cyc(1'b1, 1'b0, 1'b1);

    // Clean press held long enough for a long press, release, acknowledge.
    repeat (60) cyc(1'b0, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b1);

    // Bounce train shorter than the debounce window.
    repeat (5) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b1);
      repeat (2) cyc(1'b1, 1'b0, 1'b1);
    end
    repeat (15) cyc(1'b1, 1'b0, 1'b1);

    // Ack arriving in the same cycle as press_pulse.
    ack_on_pulse = 1'b1;
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    ack_on_pulse = 1'b0;
    repeat (15) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);

    // Release glitch in the middle of a long hold.
    repeat (15) cyc(1'b0, 1'b0, 1'b1);
    repeat (3)  cyc(1'b1, 1'b0, 1'b1);
    repeat (50) cyc(1'b0, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, 1'b0, 1'b1);

    // Reset while pressed with a pending request.
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (30) cyc(1'b1, 1'b0, 1'b1);

    // Randomised pad segments, sporadic ack and rare reset.
    raw_lvl = 1'b1; seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        raw_lvl = ~raw_lvl;
        seg = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(5, 60);
      end
      seg--;
      cyc(raw_lvl, logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 999) != 0));
    end

    @(negedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
